// File: rtl/ldu_addr_pipe.sv
// Load-unit address pipe: operand collect (OC) then address calc (AC).
// Takes issue from the LDU IQ and emits VA requests to dTLB/dcache.
package core_types_pkg;
  localparam int PRF_BANK_COUNT = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int LOG_LDU_CQ_ENTRIES = 4;

  typedef struct packed {
    logic [3:0]                    op;
    logic [11:0]                   imm12;
    logic [LOG_LDU_CQ_ENTRIES-1:0] cq_index;
  } oc_t;

  typedef struct packed {
    logic [3:0]                    op;
    logic [31:0]                   va;
    logic                          misaligned;
    logic [LOG_LDU_CQ_ENTRIES-1:0] cq_index;
  } ac_t;
endpackage

module ldu_addr_pipe
  import core_types_pkg::*;
#(
  parameter int FAST_FORWARD_PIPE_COUNT = 4,
  parameter int LOG_FAST_FORWARD_PIPE_COUNT = $clog2(FAST_FORWARD_PIPE_COUNT)
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic                                   issue_valid,
  input  logic [3:0]                             issue_op,
  input  logic [11:0]                            issue_imm12,
  input  logic                                   issue_A_is_reg,
  input  logic                                   issue_A_is_bus_forward,
  input  logic                                   issue_A_is_fast_forward,
  input  logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] issue_A_fast_forward_pipe,
  input  logic [LOG_PRF_BANK_COUNT-1:0]          issue_A_bank,
  input  logic [LOG_LDU_CQ_ENTRIES-1:0]          issue_cq_index,
  output logic                                   issue_ready,
  input  logic [PRF_BANK_COUNT-1:0]              A_reg_read_ack_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][31:0]        A_reg_read_data_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][31:0]        WB_bus_data_by_bank,
  input  logic [FAST_FORWARD_PIPE_COUNT-1:0][31:0] fast_forward_data_by_pipe,
  output logic                                   ldu_req_valid,
  output logic [3:0]                             ldu_req_op,
  output logic [31:0]                            ldu_req_VA,
  output logic                                   ldu_req_misaligned,
  output logic [LOG_LDU_CQ_ENTRIES-1:0]          ldu_req_cq_index,
  input  logic                                   ldu_req_ready
);

  oc_t                                   oc;
  logic                                  oc_valid;
  logic                                  oc_first;
  logic                                  oc_is_reg;
  logic                                  oc_is_bus;
  logic                                  oc_is_fast;
  logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] oc_pipe;
  logic [LOG_PRF_BANK_COUNT-1:0]         oc_bank;
  logic                                  oc_a_have;
  logic [31:0]                           oc_a_saved;

  ac_t  ac;
  logic ac_valid;

  logic        a_avail;
  logic [31:0] a_live;
  logic [31:0] va;
  logic        misaligned;
  logic        oc_advance;
  logic        issue_fire;

  // Forwarded operands are only live in the first OC cycle.
  always_comb begin
    a_avail = 1'b0;
    a_live  = '0;
    if (oc_a_have) begin
      a_avail = 1'b1;
      a_live  = oc_a_saved;
    end else begin
      priority case (1'b1)
        oc_is_reg: begin
          a_avail = A_reg_read_ack_by_bank[oc_bank];
          a_live  = A_reg_read_data_by_bank[oc_bank];
        end
        oc_is_bus: begin
          a_avail = oc_first;
          a_live  = WB_bus_data_by_bank[oc_bank];
        end
        oc_is_fast: begin
          a_avail = oc_first;
          a_live  = fast_forward_data_by_pipe[oc_pipe];
        end
        default: begin
          a_avail = 1'b1;
          a_live  = '0;
        end
      endcase
    end
  end

  always_comb begin
    va = a_live + {{20{oc.imm12[11]}}, oc.imm12};
    misaligned = 1'b0;
    unique case (oc.op[1:0])
      2'b01:   misaligned = va[0];
      2'b10:   misaligned = |va[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign oc_advance  = oc_valid & a_avail & (~ac_valid | ldu_req_ready);
  assign issue_ready = ~oc_valid | oc_advance;
  assign issue_fire  = issue_valid & issue_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      oc_valid   <= 1'b0;
      oc_first   <= 1'b0;
      oc         <= '0;
      oc_is_reg  <= 1'b0;
      oc_is_bus  <= 1'b0;
      oc_is_fast <= 1'b0;
      oc_pipe    <= '0;
      oc_bank    <= '0;
      oc_a_have  <= 1'b0;
      oc_a_saved <= '0;
    end else begin
      oc_first <= 1'b0;
      if (issue_fire) begin
        oc_valid   <= 1'b1;
        oc_first   <= 1'b1;
        oc_a_have  <= 1'b0;
        oc         <= '{op: issue_op,
                        imm12: issue_imm12,
                        cq_index: issue_cq_index};
        oc_is_reg  <= issue_A_is_reg;
        oc_is_bus  <= issue_A_is_bus_forward;
        oc_is_fast <= issue_A_is_fast_forward;
        oc_pipe    <= issue_A_fast_forward_pipe;
        oc_bank    <= issue_A_bank;
      end else if (oc_advance) begin
        oc_valid  <= 1'b0;
        oc_a_have <= 1'b0;
      end else if (oc_valid & a_avail & ~oc_a_have) begin
        oc_a_have  <= 1'b1;
        oc_a_saved <= a_live;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ac_valid <= 1'b0;
      ac       <= '0;
    end else if (oc_advance) begin
      ac_valid <= 1'b1;
      ac       <= '{op: oc.op,
                    va: va,
                    misaligned: misaligned,
                    cq_index: oc.cq_index};
    end else if (ldu_req_ready) begin
      ac_valid <= 1'b0;
    end
  end

  assign ldu_req_valid      = ac_valid;
  assign ldu_req_op         = ac.op;
  assign ldu_req_VA         = ac.va;
  assign ldu_req_misaligned = ac.misaligned;
  assign ldu_req_cq_index   = ac.cq_index;

endmodule

// File: tb/tb_ldu_addr_pipe.sv
// Directed bench for ldu_addr_pipe.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_ldu_addr_pipe;
  import core_types_pkg::*;

  localparam int FFN = 4;
  localparam int LFF = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic                              issue_valid;
  logic [3:0]                        issue_op;
  logic [11:0]                       issue_imm12;
  logic                              issue_A_is_reg;
  logic                              issue_A_is_bus_forward;
  logic                              issue_A_is_fast_forward;
  logic [LFF-1:0]                    issue_A_fast_forward_pipe;
  logic [LOG_PRF_BANK_COUNT-1:0]     issue_A_bank;
  logic [LOG_LDU_CQ_ENTRIES-1:0]     issue_cq_index;
  logic                              issue_ready;
  logic [PRF_BANK_COUNT-1:0]         A_reg_read_ack_by_bank;
  logic [PRF_BANK_COUNT-1:0][31:0]   A_reg_read_data_by_bank;
  logic [PRF_BANK_COUNT-1:0][31:0]   WB_bus_data_by_bank;
  logic [FFN-1:0][31:0]              fast_forward_data_by_pipe;
  logic                              ldu_req_valid;
  logic [3:0]                        ldu_req_op;
  logic [31:0]                       ldu_req_VA;
  logic                              ldu_req_misaligned;
  logic [LOG_LDU_CQ_ENTRIES-1:0]     ldu_req_cq_index;
  logic                              ldu_req_ready;

  ldu_addr_pipe #(
    .FAST_FORWARD_PIPE_COUNT(FFN)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .issue_valid(issue_valid),
    .issue_op(issue_op),
    .issue_imm12(issue_imm12),
    .issue_A_is_reg(issue_A_is_reg),
    .issue_A_is_bus_forward(issue_A_is_bus_forward),
    .issue_A_is_fast_forward(issue_A_is_fast_forward),
    .issue_A_fast_forward_pipe(issue_A_fast_forward_pipe),
    .issue_A_bank(issue_A_bank),
    .issue_cq_index(issue_cq_index),
    .issue_ready(issue_ready),
    .A_reg_read_ack_by_bank(A_reg_read_ack_by_bank),
    .A_reg_read_data_by_bank(A_reg_read_data_by_bank),
    .WB_bus_data_by_bank(WB_bus_data_by_bank),
    .fast_forward_data_by_pipe(fast_forward_data_by_pipe),
    .ldu_req_valid(ldu_req_valid),
    .ldu_req_op(ldu_req_op),
    .ldu_req_VA(ldu_req_VA),
    .ldu_req_misaligned(ldu_req_misaligned),
    .ldu_req_cq_index(ldu_req_cq_index),
    .ldu_req_ready(ldu_req_ready)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [11:0] imm,
                       input logic is_reg,
                       input logic is_bus,
                       input logic is_fast,
                       input logic [LFF-1:0] pipe,
                       input logic [1:0] bank,
                       input logic [3:0] cq);
    issue_valid = 1'b1;
    issue_op = op;
    issue_imm12 = imm;
    issue_A_is_reg = is_reg;
    issue_A_is_bus_forward = is_bus;
    issue_A_is_fast_forward = is_fast;
    issue_A_fast_forward_pipe = pipe;
    issue_A_bank = bank;
    issue_cq_index = cq;
  endtask

  task automatic chk_req(input string tag,
                         input logic [31:0] va,
                         input logic mis,
                         input logic [3:0] cq,
                         input logic [3:0] op);
    chk({tag, "_valid"}, ldu_req_valid, 1);
    chk({tag, "_va"}, ldu_req_VA, va);
    chk({tag, "_mis"}, ldu_req_misaligned, mis);
    chk({tag, "_cq"}, ldu_req_cq_index, cq);
    chk({tag, "_op"}, ldu_req_op, op);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic [11:0] imm_tab [8];
  logic [31:0] va_tab  [8];
  logic [3:0]  q_cq [$];
  logic [31:0] q_va [$];

  initial begin
    logic rdy;
    logic stall;
    logic [31:0] p_va;
    logic [3:0] p_cq;
    int sent;
    int got;

    imm_tab = '{12'h000, 12'h004, 12'h7FC, 12'h800,
                12'hFFF, 12'h123, 12'h010, 12'hABC};
    va_tab  = '{32'h0000_0000, 32'h0000_0004,
                32'h0000_07FC, 32'hFFFF_F800,
                32'hFFFF_FFFF, 32'h0000_0123,
                32'h0000_0010, 32'hFFFF_FABC};

    issue_valid = 1'b0;
    issue_op = '0;
    issue_imm12 = '0;
    issue_A_is_reg = 1'b0;
    issue_A_is_bus_forward = 1'b0;
    issue_A_is_fast_forward = 1'b0;
    issue_A_fast_forward_pipe = '0;
    issue_A_bank = '0;
    issue_cq_index = '0;
    A_reg_read_ack_by_bank = '0;
    A_reg_read_data_by_bank = '0;
    WB_bus_data_by_bank = '0;
    fast_forward_data_by_pipe = '0;
    ldu_req_ready = 1'b1;

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_valid", ldu_req_valid, 0);
    chk("rst_va", ldu_req_VA, 0);
    chk("rst_mis", ldu_req_misaligned, 0);
    chk("rst_cq", ldu_req_cq_index, 0);
    nRST = 1'b1;
    #1 chk("rst_issue_ready", issue_ready, 1);

    // zero source LW, imm 0x7FF
    issue(4'b0010, 12'h7FF, 0, 0, 0, 0, 0, 4'd1);
    @(negedge CLK);
    issue_valid = 1'b0;
    chk("t1_early", ldu_req_valid, 0);
    @(negedge CLK);
    chk_req("t1", 32'h0000_07FF, 1, 4'd1, 4'b0010);

    // zero source LHU, odd address
    issue(4'b0101, 12'h001, 0, 0, 0, 0, 0, 4'd6);
    @(negedge CLK);
    issue_valid = 1'b0;
    chk("t1b_early", ldu_req_valid, 0);
    @(negedge CLK);
    chk_req("t1b", 32'h0000_0001, 1, 4'd6, 4'b0101);

    // reg source bank 1, ack 3 cycles late
    issue(4'b0010, 12'hFFC, 1, 0, 0, 0, 2'd1, 4'd2);
    A_reg_read_data_by_bank[1] = 32'h5555_5555;
    @(negedge CLK);
    issue_valid = 1'b0;
    A_reg_read_ack_by_bank[0] = 1'b1;
    A_reg_read_data_by_bank[0] = 32'h1234_5678;
    #1 chk("t2_ready_w1", issue_ready, 0);
    @(negedge CLK);
    A_reg_read_ack_by_bank = '0;
    #1 chk("t2_ready_w2", issue_ready, 0);
    @(negedge CLK);
    chk("t2_valid_w3", ldu_req_valid, 0);
    #1 chk("t2_ready_w3", issue_ready, 0);
    @(negedge CLK);
    A_reg_read_ack_by_bank[1] = 1'b1;
    A_reg_read_data_by_bank[1] = 32'h0000_1000;
    #1 chk("t2_ready_ack", issue_ready, 1);
    @(negedge CLK);
    A_reg_read_ack_by_bank = '0;
    A_reg_read_data_by_bank[1] = 32'h5555_5555;
    chk_req("t2", 32'h0000_0FFC, 0, 4'd2, 4'b0010);

    // bus forward captured while AC stalls
    issue(4'b0000, 12'h010, 0, 0, 0, 0, 0, 4'd3);
    @(negedge CLK);
    issue(4'b0010, 12'h004, 0, 1, 0, 0, 2'd2, 4'd4);
    WB_bus_data_by_bank[2] = 32'h8000_0000;
    ldu_req_ready = 1'b0;
    chk("t3_empty", ldu_req_valid, 0);
    @(negedge CLK);
    issue_valid = 1'b0;
    chk_req("t3_a_s0", 32'h0000_0010, 0, 4'd3, 4'b0000);
    #1 chk("t3_ready_full", issue_ready, 0);
    @(negedge CLK);
    WB_bus_data_by_bank[2] = 32'hDEAD_BEEF;
    chk_req("t3_a_s1", 32'h0000_0010, 0, 4'd3, 4'b0000);
    @(negedge CLK);
    chk_req("t3_a_s2", 32'h0000_0010, 0, 4'd3, 4'b0000);
    @(negedge CLK);
    chk_req("t3_a_s3", 32'h0000_0010, 0, 4'd3, 4'b0000);
    ldu_req_ready = 1'b1;
    @(negedge CLK);
    chk_req("t3_b", 32'h8000_0004, 0, 4'd4, 4'b0010);
    WB_bus_data_by_bank[2] = '0;

    // fast forward pipe 3, wraps to zero
    fast_forward_data_by_pipe = {32'hFFFF_FFFF, 32'h1111_1111,
                                 32'h2222_2222, 32'h3333_3333};
    issue(4'b0001, 12'h001, 0, 0, 1, 2'd3, 0, 4'd5);
    @(negedge CLK);
    issue_valid = 1'b0;
    chk("t4_early", ldu_req_valid, 0);
    @(negedge CLK);
    chk_req("t4", 32'h0000_0000, 0, 4'd5, 4'b0001);
    @(negedge CLK);
    chk("t4_drained", ldu_req_valid, 0);

    // 8 back-to-back issues, ready toggling
    rdy = 1'b1;
    stall = 1'b0;
    p_va = '0;
    p_cq = '0;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      if (stall) begin
        chk("t5_hold_valid", ldu_req_valid, 1);
        chk("t5_hold_va", ldu_req_VA, p_va);
        chk("t5_hold_cq", ldu_req_cq_index, p_cq);
      end
      if (ldu_req_valid) begin
        if (q_cq.size() == 0) begin
          chk("t5_spurious", ldu_req_valid, 0);
        end else begin
          chk("t5_cq", ldu_req_cq_index, q_cq[0]);
          chk("t5_va", ldu_req_VA, q_va[0]);
          chk("t5_mis", ldu_req_misaligned, 0);
        end
      end
      ldu_req_ready = rdy;
      if (ldu_req_valid && rdy && q_cq.size() != 0) begin
        void'(q_cq.pop_front());
        void'(q_va.pop_front());
        got++;
      end
      stall = ldu_req_valid & ~rdy;
      p_va = ldu_req_VA;
      p_cq = ldu_req_cq_index;
      rdy = ~rdy;
      if (sent < 8) begin
        issue(4'b0000, imm_tab[sent], 0, 0, 0, 0, 0, 4'(sent + 8));
        #1;
        if (issue_ready) begin
          q_cq.push_back(4'(sent + 8));
          q_va.push_back(va_tab[sent]);
          sent++;
        end
      end else begin
        issue_valid = 1'b0;
      end
      @(negedge CLK);
    end
    issue_valid = 1'b0;
    chk("t5_count", got, 8);

    // reset with both stages full
    ldu_req_ready = 1'b1;
    @(negedge CLK);
    ldu_req_ready = 1'b0;
    issue(4'b0000, 12'h020, 0, 0, 0, 0, 0, 4'd7);
    @(negedge CLK);
    issue(4'b0000, 12'h040, 0, 0, 0, 0, 0, 4'd8);
    @(negedge CLK);
    issue_valid = 1'b0;
    chk("t6_full_valid", ldu_req_valid, 1);
    #1 chk("t6_full_ready", issue_ready, 0);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_valid", ldu_req_valid, 0);
    chk("t6_rst_ready", issue_ready, 1);
    @(negedge CLK);
    nRST = 1'b1;
    ldu_req_ready = 1'b1;
    #1 chk("t6_rel_ready", issue_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t6_no_req", ldu_req_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
